// File: rtl/inst_defs.sv
// ============================================================================
// Module      : inst_defs (package)
// Description : funct3 encodings for RV32 load/store instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_defs;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

`default_nettype wire

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg (package)
// Description : Shared types for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Word-organised data RAM with synchronous read, load extension
//               and store byte-lane merging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
  import inst_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 16,
  localparam int ADDR_W = $clog2(SIZE) + 2
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              wr_en,
  input  logic [2:0]        funct3,
  output logic [WIDTH-1:0]  data_out
);

  logic [WIDTH-1:0]  mem_q [SIZE];
  logic [WIDTH-1:0]  data_out_q;
  logic [ADDR_W-3:0] w_idx;
  logic [4:0]        w_shift;
  logic [WIDTH-1:0]  w_word;
  logic [WIDTH-1:0]  w_shifted;
  logic [WIDTH-1:0]  w_rdata;
  logic [WIDTH-1:0]  w_mask;
  logic [WIDTH-1:0]  w_wdata;

  assign w_idx     = addr[ADDR_W-1:2];
  assign w_shift   = {addr[1:0], 3'b000};
  assign w_word    = mem_q[w_idx];
  assign w_shifted = w_word >> w_shift;

  always_comb begin
    case (funct3)
      LB:      w_rdata = {{(WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      LBU:     w_rdata = {{(WIDTH-8){1'b0}}, w_shifted[7:0]};
      LH:      w_rdata = {{(WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      LHU:     w_rdata = {{(WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: w_rdata = w_word;
    endcase
  end

  // Sub-word stores only touch their own lanes of the addressed word.
  always_comb begin
    w_mask  = '1;
    w_wdata = data_in;
    if (funct3 == SB) begin
      w_mask  = {{(WIDTH-8){1'b0}}, 8'hFF} << w_shift;
      w_wdata = data_in << w_shift;
    end else if (funct3 == SH) begin
      w_mask  = {{(WIDTH-16){1'b0}}, 16'hFFFF} << w_shift;
      w_wdata = data_in << w_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[w_idx] <= (w_word & ~w_mask) | (w_wdata & w_mask);
    end
    data_out_q <= w_rdata;
  end

  assign data_out = data_out_q;

endmodule

`default_nettype wire

// File: rtl/lsu_fault_check.sv
// ============================================================================
// Module      : lsu_fault_check
// Description : Combinational alignment / funct3 legality decode for a request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_fault_check
  import inst_defs::*;
(
  input  logic [2:0] funct3,
  input  logic       we,
  input  logic [1:0] addr,
  output logic       misaligned,
  output logic       illegal
);

  always_comb begin
    misaligned = 1'b0;
    if (funct3 == LH || funct3 == LHU) begin
      misaligned = addr[0];
    end else if (funct3 == LW) begin
      misaligned = |addr;
    end

    if (we) begin
      illegal = !(funct3 inside {SB, SH, SW});
    end else begin
      illegal = !(funct3 inside {LB, LH, LW, LBU, LHU});
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store sequencer in front of data_memory.
//               Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
  import inst_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 16,
  localparam int ADDR_W = $clog2(SIZE) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_illegal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data_in,
  output logic              mem_wr_en,
  output logic [2:0]        mem_funct3,
  input  logic [WIDTH-1:0]  mem_data_out
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_data_in_q, mem_data_in_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              we_q, we_d;
  logic              resp_load_q, resp_load_d;
  logic              resp_illegal_q, resp_illegal_d;
  logic              resp_misaligned_q, resp_misaligned_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;

  logic w_misaligned;
  logic w_illegal;
  logic w_mis_trap;
  logic w_accept;

  lsu_fault_check u_fault_check (
    .funct3     (req_funct3),
    .we         (req_we),
    .addr       (req_addr[1:0]),
    .misaligned (w_misaligned),
    .illegal    (w_illegal)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis_trap = w_misaligned;
`else
  logic w_unused_misaligned;
  assign w_unused_misaligned = w_misaligned;
  assign w_mis_trap          = 1'b0;
`endif

  assign w_accept = req_valid && req_ready_q;

  always_comb begin
    state_d           = state_q;
    mem_addr_d        = mem_addr_q;
    mem_data_in_d     = mem_data_in_q;
    mem_funct3_d      = mem_funct3_q;
    we_d              = we_q;
    resp_load_d       = resp_load_q;
    resp_illegal_d    = resp_illegal_q;
    resp_misaligned_d = resp_misaligned_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          resp_illegal_d    = w_illegal;
          resp_misaligned_d = w_mis_trap && !w_illegal;
          // Faulting requests never reach memory; the mem_* bus keeps its last access.
          if (w_illegal || w_mis_trap) begin
            resp_load_d = 1'b0;
            we_d        = 1'b0;
            state_d     = RESP;
          end else begin
            mem_addr_d    = req_addr;
            mem_data_in_d = req_wdata;
            mem_funct3_d  = req_funct3;
            we_d          = req_we;
            resp_load_d   = !req_we;
            state_d       = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_load_d       = 1'b0;
          resp_illegal_d    = 1'b0;
          resp_misaligned_d = 1'b0;
          state_d           = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      mem_addr_q        <= '0;
      mem_data_in_q     <= '0;
      mem_funct3_q      <= LW;
      we_q              <= 1'b0;
      resp_load_q       <= 1'b0;
      resp_illegal_q    <= 1'b0;
      resp_misaligned_q <= 1'b0;
      req_ready_q       <= 1'b1;
      resp_valid_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      mem_addr_q        <= mem_addr_d;
      mem_data_in_q     <= mem_data_in_d;
      mem_funct3_q      <= mem_funct3_d;
      we_q              <= we_d;
      resp_load_q       <= resp_load_d;
      resp_illegal_q    <= resp_illegal_d;
      resp_misaligned_q <= resp_misaligned_d;
      req_ready_q       <= req_ready_d;
      resp_valid_q      <= resp_valid_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_illegal    = resp_illegal_q;
  assign resp_misaligned = resp_misaligned_q;
  assign mem_addr        = mem_addr_q;
  assign mem_data_in     = mem_data_in_q;
  assign mem_funct3      = mem_funct3_q;

  // Reset must kill a store sitting in ISSUE before the memory samples it.
  assign mem_wr_en  = (state_q == ISSUE) && we_q && !reset;

  // Memory read data is already stable in RESP since address and funct3 are held.
  assign resp_rdata = (resp_valid_q && resp_load_q) ? mem_data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit + data_memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
  import inst_defs::*;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_we, resp_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready, resp_valid, resp_misaligned, resp_illegal;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in, mem_data_out;
  logic              mem_wr_en;
  logic [2:0]        mem_funct3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.WIDTH(32), .SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
    .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
  );

  data_memory #(.WIDTH(32), .SIZE(16)) u_mem (
    .clk(clk), .addr(mem_addr), .data_in(mem_data_in), .wr_en(mem_wr_en),
    .funct3(mem_funct3), .data_out(mem_data_out)
  );

  // Reference model: byte-addressed memory plus the one outstanding transaction.
  logic [7:0]  mm [64];
  bit          known [64];
  bit          pend, p_we, p_fault, p_ill, p_mis, p_dc;
  int          p_acc;
  logic [5:0]  p_addr;
  logic [2:0]  p_f3;
  logic [31:0] p_rdata, p_wdata;
  logic [31:0] last_rdata;
  logic        last_mis, last_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int valid_cyc();
    return p_fault ? p_acc : p_acc + 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a, output bit dc);
    int b = a - (a % 4);
    logic [31:0] r;
    r  = '0;
    dc = 1'b0;
    case (f3)
      LB:  begin r = {{24{mm[a][7]}}, mm[a]}; dc = !known[a]; end
      LBU: begin r = {24'h0, mm[a]};          dc = !known[a]; end
      LH:  begin r = {{16{mm[a+1][7]}}, mm[a+1], mm[a]}; dc = !(known[a] && known[a+1]); end
      LHU: begin r = {16'h0, mm[a+1], mm[a]};            dc = !(known[a] && known[a+1]); end
      LW:  begin
        r  = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
        dc = !(known[b] && known[b+1] && known[b+2] && known[b+3]);
      end
      default: dc = 1'b1;
    endcase
    return r;
  endfunction

  task automatic model_store(input logic [2:0] f3, input int a, input logic [31:0] d);
    int n = (f3 == SB) ? 1 : (f3 == SH) ? 2 : 4;
    int base = (n == 4) ? a - (a % 4) : a;
    for (int i = 0; i < n; i++) begin
      mm[base+i]    = d[8*i +: 8];
      known[base+i] = 1'b1;
    end
  endtask

  task automatic model_accept(input bit we, input logic [2:0] f3, input logic [5:0] a,
                              input logic [31:0] wd);
    bit ill, half, word, mis, dc;
    ill  = we ? !(f3 inside {SB, SH, SW}) : !(f3 inside {LB, LH, LW, LBU, LHU});
    half = we ? (f3 == SH) : (f3 inside {LH, LHU});
    word = (f3 == LW);
    mis  = (half && a[0]) || (word && a[1:0] != 2'b00);
    p_ill = ill;
`ifdef LSU_MISALIGN_TRAP_EN
    p_mis = mis && !ill;
`else
    p_mis = 1'b0;
`endif
    p_fault = p_ill || p_mis;
    p_we = we; p_f3 = f3; p_addr = a; p_wdata = wd; p_acc = cyc;
    p_rdata = '0;
    dc = 1'b0;
    if (!p_fault && !we) p_rdata = model_load(f3, int'(a), dc);
    p_dc = dc || (mis && !p_fault);
    pend = 1'b1;
  endtask

  // Per-cycle comparison of DUT outputs against the model's outstanding transaction.
  always @(negedge clk) begin
    if (reset) begin
      chk("wr_en_in_reset", mem_wr_en, 0);
    end else if (!pend) begin
      chk("req_ready_idle", req_ready, 1);
      chk("resp_valid_idle", resp_valid, 0);
      chk("wr_en_idle", mem_wr_en, 0);
    end else begin
      chk("req_ready_busy", req_ready, 0);
      chk("wr_en", mem_wr_en, !p_fault && p_we && cyc == p_acc);
      chk("resp_valid", resp_valid, cyc >= valid_cyc());
      if (!p_fault) begin
        chk("mem_addr", mem_addr, p_addr);
        chk("mem_funct3", mem_funct3, p_f3);
        if (p_we) chk("mem_data_in", mem_data_in, p_wdata);
      end
      if (cyc >= valid_cyc()) begin
        if (!p_dc) chk("resp_rdata", resp_rdata, p_rdata);
        chk("resp_illegal", resp_illegal, p_ill);
        chk("resp_misaligned", resp_misaligned, p_mis);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [5:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    model_accept(we, f3, a, wd);
  endtask

  task automatic finish_resp(input int hold);
    while (cyc < valid_cyc() + hold) tick();
    last_rdata = resp_rdata;
    last_mis   = resp_misaligned;
    last_ill   = resp_illegal;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    if (!p_fault && p_we) model_store(p_f3, int'(p_addr), p_wdata);
    pend = 1'b0;
  endtask

  task automatic access(input bit we, input logic [2:0] f3, input logic [5:0] a,
                        input logic [31:0] wd, input int hold);
    issue(we, f3, a, wd);
    finish_resp(hold);
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_mis", resp_misaligned, 0);
    chk("rst_resp_ill", resp_illegal, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_mem_funct3", mem_funct3, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; pend = 1'b0;
    for (int i = 0; i < 64; i++) begin mm[i] = '0; known[i] = 1'b0; end
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals();

    access(1'b1, SW, 6'h0C, 32'hdeadbeef, 0);
    access(1'b0, LW, 6'h0C, 32'h0, 0);
    chk("lw_0c", last_rdata, 32'hdeadbeef);

    access(1'b1, SB, 6'h0C, 32'h00003210, 0);
    access(1'b0, LB, 6'h0C, 32'h0, 0);
    chk("lb_0c", last_rdata, 32'h00000010);
    access(1'b0, LW, 6'h0C, 32'h0, 0);
    chk("lw_0c_merged", last_rdata, 32'hdeadbe10);
    access(1'b0, LB, 6'h0D, 32'h0, 0);
    chk("lb_0d", last_rdata, 32'hffffffbe);
    access(1'b0, LBU, 6'h0F, 32'h0, 0);
    chk("lbu_0f", last_rdata, 32'h000000de);

    access(1'b1, SW, 6'h10, 32'h3210f0f0, 0);
    access(1'b0, LH, 6'h10, 32'h0, 0);
    chk("lh_10", last_rdata, 32'hfffff0f0);
    access(1'b0, LHU, 6'h10, 32'h0, 0);
    chk("lhu_10", last_rdata, 32'h0000f0f0);
    access(1'b0, LB, 6'h10, 32'h0, 0);
    chk("lb_10", last_rdata, 32'hfffffff0);
    access(1'b0, LBU, 6'h10, 32'h0, 0);
    chk("lbu_10", last_rdata, 32'h000000f0);

    access(1'b0, LW, 6'h0E, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_0e_mis", last_mis, 1);
    chk("lw_0e_rdata", last_rdata, 0);
    access(1'b1, SH, 6'h11, 32'hffffffff, 0);
    chk("sh_11_mis", last_mis, 1);
`else
    chk("lw_0e_mis", last_mis, 0);
`endif

    access(1'b0, LW, 6'h10, 32'h0, 3);
    chk("lw_10_held", last_rdata, 32'h3210f0f0);

    access(1'b0, 3'b011, 6'h00, 32'h0, 0);
    chk("ld_f3_011_ill", last_ill, 1);
    access(1'b1, 3'b100, 6'h10, 32'hffffffff, 0);
    chk("st_f3_100_ill", last_ill, 1);
    access(1'b1, 3'b111, 6'h13, 32'hffffffff, 1);
    chk("st_ill_prio_ill", last_ill, 1);
    chk("st_ill_prio_mis", last_mis, 0);
    access(1'b0, LW, 6'h10, 32'h0, 0);
    chk("lw_10_after_ill", last_rdata, 32'h3210f0f0);

    access(1'b1, SH, 6'h12, 32'haaaa5555, 0);
    access(1'b0, LW, 6'h10, 32'h0, 0);
    chk("lw_10_after_sh", last_rdata, 32'h5555f0f0);

    access(1'b1, SW, 6'h14, 32'h0badf00d, 0);
    issue(1'b1, SW, 6'h14, 32'h12345678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pend  = 1'b0;
    check_reset_vals();
    access(1'b0, LW, 6'h14, 32'h0, 0);
    chk("lw_14_not_new", last_rdata != 32'h12345678, 1);
    chk("lw_14_old", last_rdata, 32'h0badf00d);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 16, memory depth in words; ADDR_W = $clog2(SIZE)+2 byte-address bits.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request offered by the pipeline.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  access type, codes from inst_defs.sv (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  WIDTH  store data.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  pipeline consumes the response.
REQ-013 SHALL have port resp_rdata  output  WIDTH  load result; 0 for stores and faults.
REQ-014 SHALL have port resp_misaligned  output  1  access faulted on alignment.
REQ-015 SHALL have port resp_illegal  output  1  funct3 invalid for the access direction.
REQ-016 SHALL have ports mem_addr (output, ADDR_W), mem_data_in (output, WIDTH), mem_wr_en (output, 1), mem_funct3 (output, 3), mem_data_out (input, WIDTH), connecting directly to data_memory, whose read is synchronous and which performs extension and byte-lane merging itself.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-018 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready at a rising edge.
REQ-019 SHALL, on acceptance without fault, register addr/wdata/funct3/we into mem_* and enter ISSUE.
REQ-020 SHALL assert mem_wr_en only in ISSUE, and only for stores.
REQ-021 SHALL transition ISSUE -> RESP unconditionally after one cycle; resp_valid is therefore high in the 2nd cycle after the acceptance edge.
REQ-022 SHALL hold mem_addr/mem_funct3 stable in RESP with mem_wr_en=0, and drive resp_rdata = mem_data_out for loads, 0 for stores.
REQ-023 SHALL hold resp_valid and all resp_* stable until resp_ready; RESP -> IDLE on the edge where resp_ready=1.
REQ-024 SHALL flag an illegal funct3 (loads 011/110/111; stores any value >010) by entering RESP directly with resp_illegal=1, issuing no memory access.
REQ-025 SHALL ignore req_valid outside IDLE, with no queuing and no lost state; throughput is at most one access per 3 cycles.

Reset
REQ-026 SHALL, on reset, set the state to IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, resp_illegal=0, mem_wr_en=0, mem_addr=0, mem_data_in=0, and mem_funct3=LW.
REQ-027 SHALL gate mem_wr_en with !reset combinationally, so that a reset during ISSUE suppresses the pending store.
REQ-028 SHALL let reset override simultaneous acceptance or resp_ready.

Configuration
REQ-029 SHALL honour macro LSU_MISALIGN_TRAP_EN. When it is defined, misaligned accesses (H: addr[0]=1; W: addr[1:0]!=0) enter RESP directly with resp_misaligned=1, no memory access, and resp_rdata=0. When it is undefined, addresses pass unchanged to memory and resp_misaligned is tied 0.
REQ-030 SHALL give resp_illegal priority over resp_misaligned when both conditions apply.

Structure
REQ-031 SHALL place the FSM state typedef (lsu_state_t) in shared package lsu_pkg; funct3 codes remain in inst_defs.sv.
REQ-032 SHALL isolate fault decode in combinational sub-module lsu_fault_check (inputs funct3, we, addr[1:0]; outputs misaligned, illegal).

Verification (bench instantiates load_store_unit and data_memory with WIDTH=32, SIZE=16)
REQ-033 SW addr 0x0C data 0xdeadbeef, then LW 0x0C -> resp_rdata=0xdeadbeef; resp_valid high 2 cycles after each acceptance.
REQ-034 SB addr 0x0C data 0x00003210 after REQ-033, then LB 0x0C -> 0x00000010; LW -> 0xdeadbe10.
REQ-035 SW 0x10 data 0x3210f0f0; then LH -> 0xfffff0f0, LHU -> 0x0000f0f0, LB -> 0xfffffff0, LBU -> 0x000000f0.
REQ-036 LW addr 0x0E with macro defined -> resp_misaligned=1, mem_wr_en never high; without macro -> resp_misaligned=0 and an access is issued.
REQ-037 Hold resp_ready=0 for 3 cycles -> resp_valid and resp_rdata are stable and req_ready=0 throughout; the next request is accepted the cycle after resp_ready=1.
REQ-038 Assert reset during ISSUE of SW 0x14 data 0x12345678 -> a subsequent LW 0x14 does not return 0x12345678 and all outputs match their REQ-026 reset values.
